// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// bit-counter width.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, valid/ready on both sides.
// Define BIT_SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum, fa_cout;

  fa_cell u_fa_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case, so no branch can infer a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Shift-then-insert keeps this valid for WIDTH == 1.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
        sa_d             = sa_q >> 1;
        sb_d             = sb_q >> 1;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: datapath flops are reset as well; they are a few bits, not a memory array.
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8); covers ovf when
// BIT_SERIAL_ADDER_OVF_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, check RUN flags and exact latency; leaves DUT in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] exp_sum, input logic exp_cout);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    repeat (W - 1) step();
    check({tag, "_out_valid_early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'h00);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      step();
    end

    // 0x05 + 0x03.
    run_op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    step();
    check("add_5_3_idle_valid", 32'(out_valid), 32'd0);
    check("add_5_3_idle_ready", 32'(in_ready), 32'd1);
    check("add_5_3_idle_busy", 32'(busy), 32'd0);

    run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    step();
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    step();
    run_op("add_c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    step();

    // Backpressure with a stray in_valid pulse during RUN.
    out_ready = 1'b0;
    a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    check("bp_in_ready_run", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    repeat (W - 3) step();
    check("bp_out_valid_early", 32'(out_valid), 32'd0);
    step();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h4B);
      check("bp_hold_cout", 32'(cout), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_drop_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_sum_kept", 32'(sum), 32'h4B);
    step();
    check("bp_no_queue_busy", 32'(busy), 32'd0);
    check("bp_no_queue_valid", 32'(out_valid), 32'd0);

    // Reset in the 4th RUN cycle of 0xAA + 0x55.
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'h00);
    check("mid_rst_cout", 32'(cout), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      check("mid_rst_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    step();

`ifdef BIT_SERIAL_ADDER_OVF_EN
    run_op("ovf_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("ovf_7f_1_ovf", 32'(ovf), 32'd1);
    step();
    run_op("ovf_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    check("ovf_ff_1_ovf", 32'(ovf), 32'd0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial N-bit adder that drives a one-bit full-adder cell, LSB first, one bit per clock.
- A flip-flop holds the carry between bits.
- Accepts operand pairs on a valid/ready input handshake and returns the sum and carry-out on a valid/ready output handshake.
- Sits directly upstream of, and wraps, the combinational full-adder cell, sequencing operand bits into it and collecting its sum/cout.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b/cin is presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  addend A (unsigned, or two's complement with the optional feature).
- b  input  WIDTH  addend B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/cout are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- State machine: IDLE, RUN, DONE. State, bit counter, and all registers are updated only on clk rising edge.
- Reset (rst=1 at an edge):
  - state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; busy=0; carry flop=0; counter=0.
  - Reset overrides every other event, including mid-RUN and DONE with a pending result. The partial result is discarded and no out_valid pulse is produced.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready:
    - load shift registers sa<=a and sb<=b;
    - carry<=cin; cnt<=0; sum register<=0;
    - go to RUN.
  - Inputs are sampled only at this edge. Later changes on a/b/cin have no effect.
- RUN:
  - in_ready=0. in_valid is ignored and not queued.
  - Each cycle the full-adder cell sees (sa[0], sb[0], carry). At the edge:
    - the sum bit shifts into sum[WIDTH-1] while the sum register shifts right;
    - sa and sb shift right;
    - carry<=cell cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE and register cout<=cell cout.
  - Counter width: clog2(WIDTH), minimum 1 bit.
- DONE:
  - out_valid=1; sum/cout are stable and held for as long as out_ready=0.
  - On out_valid && out_ready, go to IDLE at that edge; out_valid drops in the next cycle.
  - sum/cout keep their last value until the next accepted operand pair.
- Latency:
  - Operand-accept edge at T gives out_valid=1 in the cycle after edge T+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH bits, handshake).
- Simultaneous events:
  - in_valid asserted during the out handshake cycle is not accepted, because in_ready=0 in DONE.
  - The earliest next accept is the first IDLE cycle.
- Width rule: the result equals the low WIDTH bits of the (WIDTH+1)-bit sum a+b+cin; cout is bit WIDTH.
- WIDTH=1: RUN lasts exactly one cycle.

Optional Feature:
- Macro: BIT_SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1): two's-complement overflow, equal to cell carry-in XOR cell carry-out at bit WIDTH-1.
  - ovf is registered with cout, reset to 0, and valid with out_valid.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Shared package bit_serial_adder_pkg:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2-based counter-width function/constant.
- One sub-module, fa_cell: combinational (a, b, cin) -> (sum, cout), instantiated once. The datapath per bit is exactly one full-adder cell.

Test Plan:
- Reset, then hold in_valid=0 -> in_ready=1, out_valid=0, sum=0x00, cout=0, busy=0 for 10 cycles.
- WIDTH=8, a=0x05, b=0x03, cin=0, out_ready=1 -> out_valid exactly 8 cycles after the accept edge; sum=0x08, cout=0; back in IDLE the cycle after.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: a=0x3C, b=0x0F, out_ready=0 for 5 cycles after out_valid -> sum=0x4B held stable and in_ready=0 throughout; out_ready=1 -> out_valid=0 next cycle. A new in_valid pulse during RUN is not accepted.
- Reset mid-operation: rst=1 at the 4th RUN cycle of a=0xAA, b=0x55 -> IDLE next cycle, out_valid never asserts, carry=0. A following 0x01+0x01 yields 0x02.
- With BIT_SERIAL_ADDER_OVF_EN:
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
